// File: rtl/vx_fpu_types_pkg.sv
// Shared FPU CSR types: fflags/fcsr layouts, CSR addresses, CSR op encoding.
package vx_fpu_types;

    localparam int unsigned INST_FRM_BITS = 3;
    localparam int unsigned FFLAGS_BITS   = 5;
    localparam int unsigned CSR_ADDR_BITS = 12;
    localparam int unsigned CSR_DATA_BITS = 32;
    localparam int unsigned CSR_VAL_BITS  = INST_FRM_BITS + FFLAGS_BITS;

    localparam logic [CSR_ADDR_BITS-1:0] CSR_FFLAGS = 12'h001;
    localparam logic [CSR_ADDR_BITS-1:0] CSR_FRM    = 12'h002;
    localparam logic [CSR_ADDR_BITS-1:0] CSR_FCSR   = 12'h003;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    // Architected fcsr bits; [31:8] always read as zero.
    typedef struct packed {
        logic [INST_FRM_BITS-1:0] frm;
        fflags_t                  fflags;
    } fcsr_t;

    typedef enum logic [1:0] {
        CSR_OP_READ  = 2'd0,
        CSR_OP_WRITE = 2'd1,
        CSR_OP_SET   = 2'd2,
        CSR_OP_CLEAR = 2'd3
    } csr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_RESP  = 2'd2
    } csr_state_e;

    function automatic logic [CSR_VAL_BITS-1:0] csr_apply(
        input csr_op_e                 op,
        input logic [CSR_VAL_BITS-1:0] old_val,
        input logic [CSR_VAL_BITS-1:0] operand
    );
        logic [CSR_VAL_BITS-1:0] res;
        case (op)
            CSR_OP_WRITE: res = operand;
            CSR_OP_SET:   res = old_val | operand;
            CSR_OP_CLEAR: res = old_val & ~operand;
            default:      res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/vx_fpu_csr_unit_if.sv
// FPU issue/commit, frm read and CSR request/response bundle for vx_fpu_csr_unit.
interface vx_fpu_csr_unit_if
    import vx_fpu_types::*;
#(
    parameter int unsigned NUM_WARPS  = 4,
    parameter int unsigned NUM_WPORTS = 2,
    parameter int unsigned NUM_RPORTS = 2
);
    localparam int unsigned NW_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

    logic                                fpu_issue_valid;
    logic [NW_BITS-1:0]                  fpu_issue_wid;
    logic                                fpu_issue_ready;
    logic [NUM_WPORTS-1:0]               fpu_wr_valid;
    logic [NUM_WPORTS*NW_BITS-1:0]       fpu_wr_wid;
    logic [NUM_WPORTS*FFLAGS_BITS-1:0]   fpu_wr_fflags;
    logic [NUM_RPORTS*NW_BITS-1:0]       frm_rd_wid;
    logic [NUM_RPORTS*INST_FRM_BITS-1:0] frm_rd_data;
    logic                                csr_req_valid;
    logic                                csr_req_ready;
    logic [NW_BITS-1:0]                  csr_req_wid;
    logic [CSR_ADDR_BITS-1:0]            csr_req_addr;
    logic [1:0]                          csr_req_op;
    logic [CSR_DATA_BITS-1:0]            csr_req_data;
    logic                                csr_rsp_valid;
    logic [CSR_DATA_BITS-1:0]            csr_rsp_data;
    logic                                csr_rsp_ready;
    logic [31:0]                         perf_stall_cycles;
    logic [31:0]                         perf_flag_events;

    modport master (
        output fpu_issue_valid, fpu_issue_wid, fpu_wr_valid, fpu_wr_wid, fpu_wr_fflags,
               frm_rd_wid, csr_req_valid, csr_req_wid, csr_req_addr, csr_req_op,
               csr_req_data, csr_rsp_ready,
        input  fpu_issue_ready, frm_rd_data, csr_req_ready, csr_rsp_valid, csr_rsp_data,
               perf_stall_cycles, perf_flag_events
    );

    modport slave (
        input  fpu_issue_valid, fpu_issue_wid, fpu_wr_valid, fpu_wr_wid, fpu_wr_fflags,
               frm_rd_wid, csr_req_valid, csr_req_wid, csr_req_addr, csr_req_op,
               csr_req_data, csr_rsp_ready,
        output fpu_issue_ready, frm_rd_data, csr_req_ready, csr_rsp_valid, csr_rsp_data,
               perf_stall_cycles, perf_flag_events
    );

endinterface

// File: rtl/vx_fpu_pend_ctr.sv
// One warp's outstanding FPU op counter: +1 issue, -N commits, registered full flag.
module vx_fpu_pend_ctr #(
    parameter int unsigned PEND_BITS = 4,
    parameter int unsigned DEC_BITS  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc_i,
    input  logic [DEC_BITS-1:0] dec_i,
    output logic                full_o,
    output logic                zero_next_c_o
);
    localparam int unsigned SUM_BITS = PEND_BITS + 1;
    localparam logic [PEND_BITS-1:0] CNT_MAX = '1;

    logic [PEND_BITS-1:0] cnt_q, cnt_d;
    logic [SUM_BITS-1:0]  sum_c, dec_c;
    logic                 underflow_c;

    // Clamp at zero on underflow; the assertion flags it.
    always_comb begin
        sum_c       = {1'b0, cnt_q} + SUM_BITS'(inc_i);
        dec_c       = SUM_BITS'(dec_i);
        underflow_c = dec_c > sum_c;
        cnt_d       = underflow_c ? '0 : PEND_BITS'(sum_c - dec_c);
    end

    assign zero_next_c_o = (cnt_d == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            full_o <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            full_o <= (cnt_d == CNT_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!underflow_c) else $error("vx_fpu_pend_ctr: commit without outstanding op");
        end
    end

endmodule

// File: rtl/vx_fpu_csr_unit.sv
// Per-warp frm/fflags holder between FPU pipes and the CSR unit; fflags/fcsr accesses drain the warp.
// Optional perf counters enabled by defining FPU_CSR_PERF_EN.
module vx_fpu_csr_unit
    import vx_fpu_types::*;
#(
    parameter int unsigned NUM_WARPS  = 4,
    parameter int unsigned NUM_WPORTS = 2,
    parameter int unsigned NUM_RPORTS = 2,
    parameter int unsigned PEND_BITS  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    vx_fpu_csr_unit_if.slave csr_bus
);
    localparam int unsigned NW_BITS  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int unsigned DEC_BITS = $clog2(NUM_WPORTS + 1);

    csr_state_e                state_q, state_d;
    logic [NW_BITS-1:0]        cap_wid_q, cap_wid_d;
    logic [CSR_ADDR_BITS-1:0]  cap_addr_q, cap_addr_d;
    csr_op_e                   cap_op_q, cap_op_d;
    logic [CSR_VAL_BITS-1:0]   cap_data_q, cap_data_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [CSR_VAL_BITS-1:0]   rsp_data_q, rsp_data_d;

    logic [FFLAGS_BITS-1:0]    fflags_q [NUM_WARPS];
    logic [FFLAGS_BITS-1:0]    fflags_d [NUM_WARPS];
    logic [INST_FRM_BITS-1:0]  frm_q    [NUM_WARPS];
    logic [INST_FRM_BITS-1:0]  frm_d    [NUM_WARPS];
    logic [INST_FRM_BITS-1:0]  frm_rd_q [NUM_RPORTS];

    logic [FFLAGS_BITS-1:0]    commit_or_c  [NUM_WARPS];
    logic [DEC_BITS-1:0]       commit_cnt_c [NUM_WARPS];
    logic [NUM_WARPS-1:0]      pend_full, pend_zero_next;
    logic                      issue_fire_c, needs_drain_c;

    logic                      exec_c;
    logic [NW_BITS-1:0]        ex_wid_c;
    logic [CSR_ADDR_BITS-1:0]  ex_addr_c;
    csr_op_e                   ex_op_c;
    logic [CSR_VAL_BITS-1:0]   ex_data_c, old_val_c, new_val_c;
    fcsr_t                     old_fcsr_c, new_fcsr_c;

    // Merge same-cycle commits per warp and count them for the pending counters.
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            commit_or_c[w]  = '0;
            commit_cnt_c[w] = '0;
            for (int p = 0; p < NUM_WPORTS; p++) begin
                if (csr_bus.fpu_wr_valid[p] &&
                    csr_bus.fpu_wr_wid[p*NW_BITS +: NW_BITS] == NW_BITS'(w)) begin
                    commit_or_c[w]  = commit_or_c[w] | csr_bus.fpu_wr_fflags[p*FFLAGS_BITS +: FFLAGS_BITS];
                    commit_cnt_c[w] = commit_cnt_c[w] + DEC_BITS'(1);
                end
            end
        end
    end

    assign csr_bus.fpu_issue_ready = !pend_full[csr_bus.fpu_issue_wid] &&
                                     !(state_q == ST_DRAIN && cap_wid_q == csr_bus.fpu_issue_wid);
    assign issue_fire_c = csr_bus.fpu_issue_valid && csr_bus.fpu_issue_ready;

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_pend
        vx_fpu_pend_ctr #(.PEND_BITS(PEND_BITS), .DEC_BITS(DEC_BITS)) u_ctr (
            .clk           (clk),
            .rst_n         (reset_n),
            .inc_i         (issue_fire_c && csr_bus.fpu_issue_wid == NW_BITS'(w)),
            .dec_i         (commit_cnt_c[w]),
            .full_o        (pend_full[w]),
            .zero_next_c_o (pend_zero_next[w])
        );
    end

    // Execute either straight from the request (frm/invalid) or from the captured drained request.
    always_comb begin
        needs_drain_c = (csr_bus.csr_req_addr == CSR_FFLAGS) || (csr_bus.csr_req_addr == CSR_FCSR);
        if (state_q == ST_IDLE) begin
            exec_c    = csr_bus.csr_req_valid && !needs_drain_c;
            ex_wid_c  = csr_bus.csr_req_wid;
            ex_addr_c = csr_bus.csr_req_addr;
            ex_op_c   = csr_op_e'(csr_bus.csr_req_op);
            ex_data_c = CSR_VAL_BITS'(csr_bus.csr_req_data);
        end else begin
            exec_c    = (state_q == ST_DRAIN) && pend_zero_next[cap_wid_q];
            ex_wid_c  = cap_wid_q;
            ex_addr_c = cap_addr_q;
            ex_op_c   = cap_op_q;
            ex_data_c = cap_data_q;
        end
    end

    // Old value sees this cycle's commits, so the last drained op's flags are reported.
    always_comb begin
        old_fcsr_c.frm    = frm_q[ex_wid_c];
        old_fcsr_c.fflags = fflags_t'(fflags_q[ex_wid_c] | commit_or_c[ex_wid_c]);
        case (ex_addr_c)
            CSR_FFLAGS: old_val_c = CSR_VAL_BITS'(old_fcsr_c.fflags);
            CSR_FRM:    old_val_c = CSR_VAL_BITS'(old_fcsr_c.frm);
            CSR_FCSR:   old_val_c = old_fcsr_c;
            default:    old_val_c = '0;
        endcase
        new_val_c  = csr_apply(ex_op_c, old_val_c, ex_data_c);
        new_fcsr_c = fcsr_t'(new_val_c);
    end

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            fflags_d[w] = fflags_q[w] | commit_or_c[w];
            frm_d[w]    = frm_q[w];
        end
        if (exec_c && ex_op_c != CSR_OP_READ) begin
            case (ex_addr_c)
                CSR_FFLAGS: fflags_d[ex_wid_c] = new_val_c[FFLAGS_BITS-1:0];
                CSR_FRM:    frm_d[ex_wid_c]    = new_val_c[INST_FRM_BITS-1:0];
                CSR_FCSR: begin
                    frm_d[ex_wid_c]    = new_fcsr_c.frm;
                    fflags_d[ex_wid_c] = new_fcsr_c.fflags;
                end
                default: ;
            endcase
        end
    end

    // CSR FSM next state.
    always_comb begin
        state_d     = state_q;
        cap_wid_d   = cap_wid_q;
        cap_addr_d  = cap_addr_q;
        cap_op_d    = cap_op_q;
        cap_data_d  = cap_data_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            ST_IDLE: begin
                if (csr_bus.csr_req_valid) begin
                    cap_wid_d  = csr_bus.csr_req_wid;
                    cap_addr_d = csr_bus.csr_req_addr;
                    cap_op_d   = csr_op_e'(csr_bus.csr_req_op);
                    cap_data_d = CSR_VAL_BITS'(csr_bus.csr_req_data);
                    state_d    = needs_drain_c ? ST_DRAIN : ST_RESP;
                end
            end
            ST_DRAIN: if (exec_c) state_d = ST_RESP;
            ST_RESP: begin
                if (csr_bus.csr_rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (exec_c) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = old_val_c;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cap_wid_q   <= '0;
            cap_addr_q  <= '0;
            cap_op_q    <= CSR_OP_READ;
            cap_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            for (int w = 0; w < NUM_WARPS; w++) begin
                fflags_q[w] <= '0;
                frm_q[w]    <= '0;
            end
            for (int p = 0; p < NUM_RPORTS; p++) frm_rd_q[p] <= '0;
        end else begin
            state_q     <= state_d;
            cap_wid_q   <= cap_wid_d;
            cap_addr_q  <= cap_addr_d;
            cap_op_q    <= cap_op_d;
            cap_data_q  <= cap_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            for (int w = 0; w < NUM_WARPS; w++) begin
                fflags_q[w] <= fflags_d[w];
                frm_q[w]    <= frm_d[w];
            end
            for (int p = 0; p < NUM_RPORTS; p++)
                frm_rd_q[p] <= frm_q[csr_bus.frm_rd_wid[p*NW_BITS +: NW_BITS]];
        end
    end

    for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rd
        assign csr_bus.frm_rd_data[p*INST_FRM_BITS +: INST_FRM_BITS] = frm_rd_q[p];
    end

    assign csr_bus.csr_req_ready = (state_q == ST_IDLE);
    assign csr_bus.csr_rsp_valid = rsp_valid_q;
    assign csr_bus.csr_rsp_data  = CSR_DATA_BITS'(rsp_data_q);

`ifdef FPU_CSR_PERF_EN
    logic [31:0] perf_stall_q, perf_flag_q, flag_hits_c;

    always_comb begin
        flag_hits_c = '0;
        for (int p = 0; p < NUM_WPORTS; p++) begin
            if (csr_bus.fpu_wr_valid[p] && csr_bus.fpu_wr_fflags[p*FFLAGS_BITS +: FFLAGS_BITS] != '0)
                flag_hits_c = flag_hits_c + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_stall_q <= '0;
            perf_flag_q  <= '0;
        end else begin
            perf_stall_q <= perf_stall_q + 32'(state_q == ST_DRAIN);
            perf_flag_q  <= perf_flag_q + flag_hits_c;
        end
    end

    assign csr_bus.perf_stall_cycles = perf_stall_q;
    assign csr_bus.perf_flag_events  = perf_flag_q;
`else
    assign csr_bus.perf_stall_cycles = '0;
    assign csr_bus.perf_flag_events  = '0;
`endif

endmodule

// File: tb/tb_vx_fpu_csr_unit.sv
// Directed self-checking bench for vx_fpu_csr_unit (4 warps, 2 commit channels, 2 frm ports).
module tb_vx_fpu_csr_unit;
    import vx_fpu_types::*;

    logic clk;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    vx_fpu_csr_unit_if #(.NUM_WARPS(4), .NUM_WPORTS(2), .NUM_RPORTS(2)) bus ();

    vx_fpu_csr_unit #(
        .NUM_WARPS(4), .NUM_WPORTS(2), .NUM_RPORTS(2), .PEND_BITS(4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .csr_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.fpu_issue_valid = 1'b0;
        bus.fpu_issue_wid   = '0;
        bus.fpu_wr_valid    = '0;
        bus.fpu_wr_wid      = '0;
        bus.fpu_wr_fflags   = '0;
        bus.frm_rd_wid      = '0;
        bus.csr_req_valid   = 1'b0;
        bus.csr_req_wid     = '0;
        bus.csr_req_addr    = '0;
        bus.csr_req_op      = '0;
        bus.csr_req_data    = '0;
        bus.csr_rsp_ready   = 1'b1;
    endtask

    task automatic drive_req(input logic [1:0] wid, input logic [11:0] addr,
                             input logic [1:0] op, input logic [31:0] data);
        bus.csr_req_valid = 1'b1;
        bus.csr_req_wid   = wid;
        bus.csr_req_addr  = addr;
        bus.csr_req_op    = op;
        bus.csr_req_data  = data;
    endtask

    // Full request/response with latency measured from the fire edge; rsp_ready held high.
    task automatic csr_txn(input string tag, input logic [1:0] wid, input logic [11:0] addr,
                           input logic [1:0] op, input logic [31:0] data,
                           input logic [31:0] exp_rd, input int exp_lat);
        int lat;
        drive_req(wid, addr, op, data);
        #1;
        chk({tag, "_req_rdy"}, 32'(bus.csr_req_ready), 32'd1);
        step();
        bus.csr_req_valid = 1'b0;
        lat = 1;
        while (bus.csr_rsp_valid !== 1'b1 && lat < 50) begin
            step();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_data"}, bus.csr_rsp_data, exp_rd);
        step();
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) step();
        chk("rst_rsp_valid", 32'(bus.csr_rsp_valid), 32'd0);
        chk("rst_rsp_data", bus.csr_rsp_data, 32'd0);
        chk("rst_frm_rd", 32'(bus.frm_rd_data), 32'd0);
        chk("rst_perf_stall", bus.perf_stall_cycles, 32'd0);
        chk("rst_perf_flag", bus.perf_flag_events, 32'd0);
        reset_n = 1'b1;
        step();
        chk("post_rst_req_rdy", 32'(bus.csr_req_ready), 32'd1);
        chk("post_rst_issue_rdy", 32'(bus.fpu_issue_ready), 32'd1);

        // fcsr read after reset: two-cycle path through DRAIN
        csr_txn("fcsr_rd_w0", 2'd0, CSR_FCSR, 2'd0, 32'h0, 32'h00, 2);
        chk("frm_rd_w0", 32'(bus.frm_rd_data), 32'd0);

        // Two channels commit to warp 1 in the same cycle
        bus.fpu_issue_valid = 1'b1;
        bus.fpu_issue_wid   = 2'd1;
        repeat (2) step();
        bus.fpu_issue_valid = 1'b0;
        bus.fpu_wr_valid    = 2'b11;
        bus.fpu_wr_wid      = {2'd1, 2'd1};
        bus.fpu_wr_fflags   = {5'h10, 5'h01};
        step();
        bus.fpu_wr_valid    = 2'b00;
        bus.fpu_wr_fflags   = '0;
        csr_txn("fflags_merge_w1", 2'd1, CSR_FFLAGS, 2'd0, 32'h0, 32'h11, 2);

        // frm write on warp 2, watched on read port 0; port 1 watches warp 0
        bus.frm_rd_wid = {2'd0, 2'd2};
        step();
        drive_req(2'd2, CSR_FRM, 2'd1, 32'h3);
        #1;
        chk("frm_wr_req_rdy", 32'(bus.csr_req_ready), 32'd1);
        step();
        bus.csr_req_valid = 1'b0;
        chk("frm_wr_lat1_valid", 32'(bus.csr_rsp_valid), 32'd1);
        chk("frm_wr_old", bus.csr_rsp_data, 32'd0);
        chk("frm_rd_1cyc_old", 32'(bus.frm_rd_data), 32'h00);
        step();
        chk("frm_rd_2cyc_new", 32'(bus.frm_rd_data), 32'h03);
        chk("frm_wr_rsp_done", 32'(bus.csr_rsp_valid), 32'd0);

        // Three ops in flight on warp 0, then an fflags read must drain them
        bus.fpu_issue_valid = 1'b1;
        bus.fpu_issue_wid   = 2'd0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("issue_rdy_w0", 32'(bus.fpu_issue_ready), 32'd1);
            step();
        end
        bus.fpu_issue_valid = 1'b0;
        drive_req(2'd0, CSR_FFLAGS, 2'd0, 32'h0);
        step();
        bus.csr_req_valid = 1'b0;
        #1;
        chk("drain_req_rdy", 32'(bus.csr_req_ready), 32'd0);
        chk("drain_issue_blk_w0", 32'(bus.fpu_issue_ready), 32'd0);
        bus.fpu_issue_wid = 2'd1;
        #1;
        chk("drain_issue_ok_w1", 32'(bus.fpu_issue_ready), 32'd1);
        bus.fpu_issue_wid = 2'd0;
        bus.fpu_wr_valid  = 2'b01;
        bus.fpu_wr_wid    = {2'd0, 2'd0};
        bus.fpu_wr_fflags = '0;
        step();
        chk("drain_wait1", 32'(bus.csr_rsp_valid), 32'd0);
        bus.fpu_wr_valid  = 2'b10;
        step();
        chk("drain_wait2", 32'(bus.csr_rsp_valid), 32'd0);
        bus.fpu_wr_valid  = 2'b01;
        bus.fpu_wr_fflags = {5'h00, 5'h04};
        step();
        bus.fpu_wr_valid  = 2'b00;
        bus.fpu_wr_fflags = '0;
        chk("drain_rsp_valid", 32'(bus.csr_rsp_valid), 32'd1);
        chk("drain_rsp_data", bus.csr_rsp_data, 32'h04);
`ifdef FPU_CSR_PERF_EN
        chk("perf_stall_a", bus.perf_stall_cycles, 32'd5);
        chk("perf_flag_a", bus.perf_flag_events, 32'd3);
`else
        chk("perf_stall_a", bus.perf_stall_cycles, 32'd0);
        chk("perf_flag_a", bus.perf_flag_events, 32'd0);
`endif
        step();

        // Saturate warp 3's counter at 15
        bus.fpu_issue_valid = 1'b1;
        bus.fpu_issue_wid   = 2'd3;
        #1;
        for (int i = 0; i < 15; i++) begin
            chk("sat_issue_rdy", 32'(bus.fpu_issue_ready), 32'd1);
            step();
        end
        bus.fpu_issue_valid = 1'b0;
        #1;
        chk("sat_full_w3", 32'(bus.fpu_issue_ready), 32'd0);
        bus.fpu_issue_wid = 2'd2;
        #1;
        chk("sat_other_w2", 32'(bus.fpu_issue_ready), 32'd1);
        bus.fpu_issue_wid = 2'd3;
        bus.fpu_wr_valid  = 2'b01;
        bus.fpu_wr_wid    = {2'd3, 2'd3};
        #1;
        chk("sat_commit_cyc", 32'(bus.fpu_issue_ready), 32'd0);
        step();
        bus.fpu_wr_valid = 2'b11;
        chk("sat_release", 32'(bus.fpu_issue_ready), 32'd1);
        repeat (7) step();
        bus.fpu_wr_valid = 2'b00;
        bus.fpu_wr_wid   = '0;

        // fcsr set/clear on warp 0
        csr_txn("fflags_wr_w0", 2'd0, CSR_FFLAGS, 2'd1, 32'h0, 32'h04, 2);
        csr_txn("fcsr_set_w0", 2'd0, CSR_FCSR, 2'd2, 32'hE1, 32'h00, 2);
        csr_txn("frm_rd_w0", 2'd0, CSR_FRM, 2'd0, 32'h0, 32'h7, 1);

        bus.csr_rsp_ready = 1'b0;
        drive_req(2'd0, CSR_FFLAGS, 2'd3, 32'h01);
        step();
        bus.csr_req_valid = 1'b0;
        step();
        chk("clr_rsp_valid", 32'(bus.csr_rsp_valid), 32'd1);
        chk("clr_rsp_data", bus.csr_rsp_data, 32'h01);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("clr_hold_valid", 32'(bus.csr_rsp_valid), 32'd1);
            chk("clr_hold_data", bus.csr_rsp_data, 32'h01);
            chk("clr_hold_req_rdy", 32'(bus.csr_req_ready), 32'd0);
        end
        bus.csr_rsp_ready = 1'b1;
        step();
        chk("clr_rsp_done", 32'(bus.csr_rsp_valid), 32'd0);

        csr_txn("fcsr_rd_after", 2'd0, CSR_FCSR, 2'd0, 32'h0, 32'hE0, 2);
        csr_txn("bad_addr", 2'd0, 12'h005, 2'd1, 32'hFF, 32'h0, 1);
        chk("frm_rd_ports", 32'(bus.frm_rd_data), 32'h3B);
`ifdef FPU_CSR_PERF_EN
        chk("perf_stall_b", bus.perf_stall_cycles, 32'd9);
        chk("perf_flag_b", bus.perf_flag_events, 32'd3);
`else
        chk("perf_stall_b", bus.perf_stall_cycles, 32'd0);
        chk("perf_flag_b", bus.perf_flag_events, 32'd0);
`endif

        // Reset while a request is draining
        bus.fpu_issue_valid = 1'b1;
        bus.fpu_issue_wid   = 2'd1;
        step();
        bus.fpu_issue_valid = 1'b0;
        drive_req(2'd1, CSR_FFLAGS, 2'd0, 32'h0);
        step();
        bus.csr_req_valid = 1'b0;
        chk("mid_drain_req_rdy", 32'(bus.csr_req_ready), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_req_rdy", 32'(bus.csr_req_ready), 32'd1);
        chk("mid_rst_rsp_valid", 32'(bus.csr_rsp_valid), 32'd0);
        chk("mid_rst_frm_rd", 32'(bus.frm_rd_data), 32'd0);
        chk("mid_rst_perf", bus.perf_stall_cycles, 32'd0);
        step();
        reset_n = 1'b1;
        step();
        csr_txn("post_rst_fcsr_w1", 2'd1, CSR_FCSR, 2'd0, 32'h0, 32'h00, 2);
        csr_txn("post_rst_frm_w2", 2'd2, CSR_FRM, 2'd0, 32'h0, 32'h0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vx_fpu_csr_unit.md
Name: vx_fpu_csr_unit

Overview:
- Per-warp floating-point CSR state holder (frm, fflags) between the FPU pipelines and the CSR unit.
- Generalised successor of the single-channel FPU-to-CSR link:
  - NUM_WPORTS concurrent fflags commit channels with same-cycle OR-merge.
  - NUM_RPORTS registered frm read ports.
  - Per-warp outstanding-op tracking.
  - CSR accesses to fflags/fcsr are serialised: they drain in-flight FPU ops of that warp first.

Parameters:
- NUM_WARPS, 4: warps tracked; NW_BITS = max(1, clog2(NUM_WARPS)).
- NUM_WPORTS, 2: fflags commit channels from FPU units.
- NUM_RPORTS, 2: frm read ports (one per FPU issue slot).
- PEND_BITS, 4: per-warp outstanding-op counter width; max outstanding ops = 2^PEND_BITS-1.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- fpu_issue_valid  in  1  FPU op issued for a warp
- fpu_issue_wid  in  NW_BITS  issuing warp
- fpu_issue_ready  out  1  issue accepted; low when pending[wid] saturated or wid is being drained
- fpu_wr_valid  in  NUM_WPORTS  per-channel fflags commit
- fpu_wr_wid  in  NUM_WPORTS*NW_BITS  committing warp per channel
- fpu_wr_fflags  in  NUM_WPORTS*5  {NV,DZ,OF,UF,NX} per channel
- frm_rd_wid  in  NUM_RPORTS*NW_BITS  frm lookup warp
- frm_rd_data  out  NUM_RPORTS*3  registered frm
- csr_req_valid  in  1  CSR request valid
- csr_req_ready  out  1  CSR request accepted
- csr_req_wid  in  NW_BITS  target warp
- csr_req_addr  in  12  0x001 fflags, 0x002 frm, 0x003 fcsr
- csr_req_op  in  2  0 read, 1 write, 2 set, 3 clear
- csr_req_data  in  32  operand
- csr_rsp_valid  out  1  response valid
- csr_rsp_data  out  32  old CSR value
- csr_rsp_ready  in  1  response consumed
- perf_stall_cycles  out  32  cycles spent in DRAIN
- perf_flag_events  out  32  commits carrying non-zero fflags

Behaviour:
- Reset (asynchronous, reset_n=0):
  - All fflags=0, frm=0 (RNE), pending=0, FSM=IDLE.
  - Outputs: csr_rsp_valid=0, csr_rsp_data=0, frm_rd_data=0, perf counters=0.
  - csr_req_ready=1 and fpu_issue_ready=1 once released.
  - Reset mid-transaction drops the request silently.
- Pending counter, per warp, each cycle:
  - pending += issue_fire(wid) − popcount(write channels hitting wid).
  - Issue and commit in the same cycle net correctly.
  - Underflow is an assertion error; the counter does not wrap.
  - Saturated at 2^PEND_BITS-1 → fpu_issue_ready=0 for that wid.
- fflags commit:
  - fflags[w] |= OR of all channel fflags with wid==w, applied the same cycle.
  - Visible to CSR the next cycle.
- frm read: frm_rd_data[p] <= frm[frm_rd_wid[p]]; 1-cycle latency; a CSR frm write is visible on the read port 2 cycles after the write cycle.
- CSR FSM (IDLE, DRAIN, RESP):
  - IDLE:
    - csr_req_ready=1; on fire, capture wid/addr/op/data.
    - addr frm or an invalid addr → EXEC directly, same cycle as the RESP transition.
    - Otherwise → DRAIN.
  - DRAIN:
    - csr_req_ready=0; fpu_issue_ready=0 for the captured wid.
    - When the post-update pending[wid]==0: execute and go to RESP.
  - Execute step:
    - rdata = old value; new = data (write), old|data (set), old&~data (clear); read leaves state unchanged.
    - fcsr layout: [7:5] frm, [4:0] fflags, [31:8] zero. frm stores data[2:0] unchecked.
    - Invalid addr: rdata=0, no state change.
  - RESP:
    - csr_rsp_valid=1 and csr_rsp_data stay stable until csr_rsp_ready; then → IDLE.
    - A new request is accepted in the following cycle at the earliest.
- Minimum CSR latency: request fire to rsp_valid = 1 cycle (frm) or 2 cycles (fflags/fcsr with pending=0).

Optional Feature:
- FPU_CSR_PERF_EN defined:
  - perf_stall_cycles increments every cycle in DRAIN.
  - perf_flag_events increments by the number of channels firing with non-zero fflags.
  - Both counters wrap at 2^32.
- Undefined: both outputs tied to 0; no counter flops.

Decomposition:
- Shared package vx_fpu_types (existing): fflags_t struct, new fcsr_t, CSR address localparams (FFLAGS/FRM/FCSR), csr_op_e enum, INST_FRM_BITS.
- One sub-module vx_fpu_pend_ctr: a single warp's saturating up/multi-down counter with full/zero flags, instantiated NUM_WARPS times.

Test Plan:
- Reset, then CSR read of fcsr wid0 → rsp_data=0x00 after 2 cycles; frm_rd_data=0.
- Same cycle: ch0 wid1 fflags=0x01, ch1 wid1 fflags=0x10; then read fflags wid1 → 0x11.
- CSR write frm=3 wid2 → rsp_data=0 (old value); frm_rd_wid=2 gives frm_rd_data=3 two cycles later.
- Issue 3 ops wid0, CSR read fflags wid0 → DRAIN, ready low, issue blocked for wid0 only; after 3 commits (last fflags=0x04) → rsp 0x04; perf_stall_cycles matches DRAIN duration (PERF_EN).
- Issue 15 ops wid3 with PEND_BITS=4 → fpu_issue_ready=0; one commit → ready=1 next cycle.
- CSR set fcsr wid0 data 0xE1 → frm=7, fflags=0x01; then clear fflags 0x01 → rsp 0x01, fflags=0; hold rsp_ready=0 for 3 cycles → rsp stable.
